// File: rtl/sar_pkg.sv
// Shared types and helpers for the SAR conversion controller.
package sar_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    SAMPLE  = 4'b0010,
    COMPARE = 4'b0100,
    DECIDE  = 4'b1000
  } state_t;

  localparam int IDLE_BIT    = 0;
  localparam int SAMPLE_BIT  = 1;
  localparam int COMPARE_BIT = 2;

  // Phase counter must cover the longest window (sample window up to 15 cycles).
  localparam int MAX_PHASE = 15;

  function automatic int width_for(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sar_ctrl_if.sv
// Bundle between the SAR controller, the analog macro and the result consumer.
// The cont signal exists only when SAR_CTRL_CONT_EN is defined.
interface sar_ctrl_if #(parameter int N = 8);
  logic         cnvst;
  logic         cmp_out;
`ifdef SAR_CTRL_CONT_EN
  logic         cont;
`endif
  logic [N-1:0] sar;
  logic [N-1:0] dout;
  logic         eoc;
  logic         busy;
  logic         s_clk;
  logic         cmp_clk;
  logic [N-1:0] dac_top;
  logic [N-1:0] dac_btm;

`ifdef SAR_CTRL_CONT_EN
  modport master (input cnvst, cmp_out, cont,
                  output sar, dout, eoc, busy, s_clk, cmp_clk, dac_top, dac_btm);
  modport slave  (output cnvst, cmp_out, cont,
                  input sar, dout, eoc, busy, s_clk, cmp_clk, dac_top, dac_btm);
`else
  modport master (input cnvst, cmp_out,
                  output sar, dout, eoc, busy, s_clk, cmp_clk, dac_top, dac_btm);
  modport slave  (output cnvst, cmp_out,
                  input sar, dout, eoc, busy, s_clk, cmp_clk, dac_top, dac_btm);
`endif
endinterface

// File: rtl/sar_dac_map.sv
// Combinational CDAC switch map from SAR code, bit pointer and state.
module sar_dac_map
  import sar_pkg::*;
#(
  parameter int N  = 8,
  parameter int BW = 3
) (
  input  state_t       state,
  input  logic [N-1:0] sar,
  input  logic [BW-1:0] b,
  output logic [N-1:0] dac_top,
  output logic [N-1:0] dac_btm
);

  // Undecided bits below the pointer float both switches open.
  always_comb begin
    dac_top = '1;
    dac_btm = '0;
    if (state == COMPARE || state == DECIDE) begin
      for (int i = 0; i < N; i++) begin
        if (i >= int'(b)) begin
          dac_top[i] = sar[i];
          dac_btm[i] = ~sar[i];
        end else begin
          dac_top[i] = 1'b0;
          dac_btm[i] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/sar_ctrl.sv
// N-bit SAR ADC sequencer: sampling, comparator strobing and binary search.
// Optional back-to-back conversion without an IDLE cycle: SAR_CTRL_CONT_EN.
module sar_ctrl
  import sar_pkg::*;
#(
  parameter int N             = 8,
  parameter int SAMPLE_CYCLES = 1,
  parameter int CMP_WAIT      = 1
) (
  input  logic       clk,
  input  logic       rst,
  sar_ctrl_if.master bus
);

  localparam int BW = width_for(N - 1);
  localparam int PW = width_for(MAX_PHASE);

  state_t        state, state_n;
  logic [PW-1:0] cnt, cnt_n;
  logic [BW-1:0] b, b_n, b_dec;
  logic [N-1:0]  sar_q, sar_n;
  logic [N-1:0]  dout_q, dout_n;
  logic          eoc_q, eoc_n;
  logic [N-1:0]  dac_top_q, dac_btm_q, dac_top_n, dac_btm_n;
  logic          cont_en;

`ifdef SAR_CTRL_CONT_EN
  assign cont_en = bus.cont;
`else
  assign cont_en = 1'b0;
`endif

  assign b_dec = b - BW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      b         <= '0;
      sar_q     <= '0;
      dout_q    <= '0;
      eoc_q     <= 1'b0;
      dac_top_q <= '1;
      dac_btm_q <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      b         <= b_n;
      sar_q     <= sar_n;
      dout_q    <= dout_n;
      eoc_q     <= eoc_n;
      dac_top_q <= dac_top_n;
      dac_btm_q <= dac_btm_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    b_n     = b;
    sar_n   = sar_q;
    dout_n  = dout_q;
    eoc_n   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cnvst) begin
          state_n = SAMPLE;
          cnt_n   = PW'(SAMPLE_CYCLES - 1);
          sar_n   = '0;
        end
      end
      SAMPLE: begin
        if (cnt == '0) begin
          state_n      = COMPARE;
          cnt_n        = PW'(CMP_WAIT - 1);
          b_n          = BW'(N - 1);
          sar_n[N-1]   = 1'b1;
        end else begin
          cnt_n = cnt - PW'(1);
        end
      end
      COMPARE: begin
        if (cnt == '0) begin
          state_n = DECIDE;
        end else begin
          cnt_n = cnt - PW'(1);
        end
      end
      DECIDE: begin
        sar_n[b] = bus.cmp_out;
        if (b != '0) begin
          sar_n[b_dec] = 1'b1;
          b_n          = b_dec;
          cnt_n        = PW'(CMP_WAIT - 1);
          state_n      = COMPARE;
        end else begin
          dout_n = sar_n;
          eoc_n  = 1'b1;
          // Continuous mode re-enters sampling exactly as IDLE would, minus the idle cycle.
          if (cont_en) begin
            state_n = SAMPLE;
            cnt_n   = PW'(SAMPLE_CYCLES - 1);
            sar_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Map from next-cycle values so the registered switches line up with the state flops.
  sar_dac_map #(.N(N), .BW(BW)) u_dac_map (
    .state   (state_n),
    .sar     (sar_n),
    .b       (b_n),
    .dac_top (dac_top_n),
    .dac_btm (dac_btm_n)
  );

  assign bus.sar     = sar_q;
  assign bus.dout    = dout_q;
  assign bus.eoc     = eoc_q;
  assign bus.busy    = ~state[IDLE_BIT];
  assign bus.s_clk   = state[SAMPLE_BIT];
  assign bus.cmp_clk = state[COMPARE_BIT];
  assign bus.dac_top = dac_top_q;
  assign bus.dac_btm = dac_btm_q;

endmodule

// File: tb/tb_sar_ctrl.sv
// Self-checking bench for sar_ctrl: default 8-bit instance plus a 10-bit one.
// Continuous-mode sequence is built only when SAR_CTRL_CONT_EN is defined.
module tb_sar_ctrl;

  localparam int LIMIT = 200;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sar_ctrl_if #(.N(8))  bus_a ();
  sar_ctrl_if #(.N(10)) bus_b ();

  sar_ctrl #(.N(8), .SAMPLE_CYCLES(1), .CMP_WAIT(1)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a.master));

  sar_ctrl #(.N(10), .SAMPLE_CYCLES(3), .CMP_WAIT(2)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b.master));

  // Ideal comparator: keep the trial bit while the trial code does not exceed the input.
  logic [7:0] code_a = 8'h00;
  logic [9:0] code_b = 10'h000;
  assign bus_a.cmp_out = (bus_a.sar <= code_a);
  assign bus_b.cmp_out = (bus_b.sar <= code_b);

  logic        sel_b = 1'b0;
  logic [15:0] sar_m, dout_m, dac_top_m, dac_btm_m;
  logic        eoc_m, busy_m, s_clk_m, cmp_clk_m;
  assign sar_m     = sel_b ? 16'(bus_b.sar)     : 16'(bus_a.sar);
  assign dout_m    = sel_b ? 16'(bus_b.dout)    : 16'(bus_a.dout);
  assign dac_top_m = sel_b ? 16'(bus_b.dac_top) : 16'(bus_a.dac_top);
  assign dac_btm_m = sel_b ? 16'(bus_b.dac_btm) : 16'(bus_a.dac_btm);
  assign eoc_m     = sel_b ? bus_b.eoc     : bus_a.eoc;
  assign busy_m    = sel_b ? bus_b.busy    : bus_a.busy;
  assign s_clk_m   = sel_b ? bus_b.s_clk   : bus_a.s_clk;
  assign cmp_clk_m = sel_b ? bus_b.cmp_clk : bus_a.cmp_clk;

  int passed = 0;
  int total  = 0;
  int overlap = 0;

  always @(negedge clk) begin
    if ((bus_a.dac_top & bus_a.dac_btm) != 8'd0)  overlap++;
    if ((bus_b.dac_top & bus_b.dac_btm) != 10'd0) overlap++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int exp_latency(input int s, input int n, input int w);
    return s + n * (w + 1);
  endfunction

  int          r_lat, r_scnt, r_ccnt, r_dacerr;
  bit          r_busyok, r_eoc_after;
  logic [15:0] r_dout;

  // One conversion; sampled 1 time unit after each rising edge, j=0 is the cycle after cnvst is taken.
  task automatic convert(input bit use_b, input logic [15:0] code);
    int n, idx;
    bit prev_cmp;
    logic [15:0] full, m, top, bit_v;
    n = use_b ? 10 : 8;
    full = 16'((32'd1 << n) - 32'd1);
    if (use_b) code_b = code[9:0]; else code_a = code[7:0];
    sel_b = use_b;
    r_lat = -1; r_scnt = 0; r_ccnt = 0; r_dacerr = 0; r_busyok = 1'b1; r_dout = '0;
    idx = n; prev_cmp = 1'b0;
    @(negedge clk);
    if (use_b) bus_b.cnvst = 1'b1; else bus_a.cnvst = 1'b1;
    @(posedge clk); #1;
    bus_a.cnvst = 1'b0;
    bus_b.cnvst = 1'b0;
    for (int j = 0; j < LIMIT; j++) begin
      if (s_clk_m) begin
        r_scnt++;
        if (dac_top_m !== full || dac_btm_m !== 16'd0) r_dacerr++;
      end
      if (cmp_clk_m) begin
        r_ccnt++;
        if (!prev_cmp) begin
          if (idx > 0) idx--; else r_dacerr++;
        end
        bit_v = 16'(32'd1 << idx);
        m     = full & ~(bit_v - 16'd1);
        top   = (code & m & ~bit_v) | bit_v;
        if (dac_top_m !== top || dac_btm_m !== (m & ~top) || sar_m !== top) r_dacerr++;
      end
      prev_cmp = cmp_clk_m;
      if (eoc_m) begin
        r_lat  = j;
        r_dout = dout_m;
        if (busy_m) r_busyok = 1'b0;
        break;
      end
      if (!busy_m) r_busyok = 1'b0;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    r_eoc_after = eoc_m;
    if (dac_top_m !== full || dac_btm_m !== 16'd0) r_dacerr++;
  endtask

  typedef struct {
    logic [7:0] code;
    logic [7:0] exp_dout;
    int         exp_lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e1, e2, eocs, eoc_j, dout_bad, busy_low;
    logic [7:0] d1, d2;
    logic [15:0] rc;

    rst = 1'b1;
    bus_a.cnvst = 1'b0;
    bus_b.cnvst = 1'b0;
`ifdef SAR_CTRL_CONT_EN
    bus_a.cont = 1'b0;
    bus_b.cont = 1'b0;
`endif
    #12;
    check("rst_sar",     32'(bus_a.sar),     32'h00);
    check("rst_dout",    32'(bus_a.dout),    32'h00);
    check("rst_flags",   {28'd0, bus_a.eoc, bus_a.busy, bus_a.s_clk, bus_a.cmp_clk}, 32'h0);
    check("rst_dac_top", 32'(bus_a.dac_top), 32'hFF);
    check("rst_dac_btm", 32'(bus_a.dac_btm), 32'h00);
    check("rst_b_dac",   32'(bus_b.dac_top), 32'h3FF);
    @(negedge clk);
    rst = 1'b0;

    vecs[0] = '{8'hA5, 8'hA5, 17};
    vecs[1] = '{8'h00, 8'h00, 17};
    vecs[2] = '{8'hFF, 8'hFF, 17};
    vecs[3] = '{8'h01, 8'h01, 17};
    vecs[4] = '{8'h80, 8'h80, 17};
    vecs[5] = '{8'h7F, 8'h7F, 17};
    foreach (vecs[i]) begin
      convert(1'b0, 16'(vecs[i].code));
      check($sformatf("vec%0d_dout", i), 32'(r_dout), 32'(vecs[i].exp_dout));
      check($sformatf("vec%0d_lat", i), 32'(r_lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_sclk", i), 32'(r_scnt), 32'd1);
      check($sformatf("vec%0d_cmpclk", i), 32'(r_ccnt), 32'd8);
      check($sformatf("vec%0d_dac", i), 32'(r_dacerr), 32'd0);
      check($sformatf("vec%0d_busy_eoc", i), {30'd0, r_busyok, r_eoc_after}, 32'b10);
    end

    convert(1'b1, 16'h02C3);
    check("b_dout",   32'(r_dout), 32'h2C3);
    check("b_lat",    32'(r_lat), 32'(exp_latency(3, 10, 2)));
    check("b_sclk",   32'(r_scnt), 32'd3);
    check("b_cmpclk", 32'(r_ccnt), 32'd20);
    check("b_dac",    32'(r_dacerr), 32'd0);

    for (int k = 0; k < 12; k++) begin
      rc = 16'($urandom_range(0, 255));
      convert(1'b0, rc);
      check($sformatf("rnd_a%0d_dout", k), 32'(r_dout), 32'(rc));
      check($sformatf("rnd_a%0d_lat", k), 32'(r_lat), 32'(exp_latency(1, 8, 1)));
      check($sformatf("rnd_a%0d_dac", k), 32'(r_dacerr), 32'd0);
    end
    for (int k = 0; k < 3; k++) begin
      rc = 16'($urandom_range(0, 1023));
      convert(1'b1, rc);
      check($sformatf("rnd_b%0d_dout", k), 32'(r_dout), 32'(rc));
      check($sformatf("rnd_b%0d_lat", k), 32'(r_lat), 32'(exp_latency(3, 10, 2)));
    end

    // cnvst pulses while busy must be dropped
    convert(1'b0, 16'h003C);
    code_a = 8'h5A;
    @(negedge clk); bus_a.cnvst = 1'b1;
    @(posedge clk); #1;
    eocs = 0; eoc_j = -1; dout_bad = 0;
    for (int j = 0; j < 40; j++) begin
      bus_a.cnvst = (j == 3 || j == 9 || j == 14);
      if (bus_a.eoc) begin eocs++; eoc_j = j; end
      if (eoc_j < 0 && bus_a.dout !== 8'h3C) dout_bad++;
      if (eoc_j >= 0 && bus_a.dout !== 8'h5A) dout_bad++;
      @(posedge clk); #1;
    end
    bus_a.cnvst = 1'b0;
    check("busy_ignore_eocs", 32'(eocs), 32'd1);
    check("busy_ignore_eocj", 32'(eoc_j), 32'd17);
    check("busy_ignore_dout", 32'(dout_bad), 32'd0);

    // cnvst held high: one IDLE cycle between conversions
    code_a = 8'h4B;
    @(negedge clk); bus_a.cnvst = 1'b1;
    @(posedge clk); #1;
    e1 = -1; e2 = -1;
    for (int j = 0; j < 45; j++) begin
      if (bus_a.eoc) begin
        if (e1 < 0) e1 = j;
        else begin e2 = j; bus_a.cnvst = 1'b0; break; end
      end
      @(posedge clk); #1;
    end
    bus_a.cnvst = 1'b0;
    check("b2b_first",  32'(e1), 32'd17);
    check("b2b_second", 32'(e2), 32'd35);
    check("b2b_dout",   32'(bus_a.dout), 32'h4B);
    repeat (3) @(posedge clk);

    // reset during COMPARE of bit 4
    convert(1'b0, 16'h00C3);
    check("pre_rst_dout", 32'(r_dout), 32'hC3);
    code_a = 8'h77;
    @(negedge clk); bus_a.cnvst = 1'b1;
    @(posedge clk); #1;
    bus_a.cnvst = 1'b0;
    for (int j = 0; j < 7; j++) begin @(posedge clk); #1; end
    check("mid_cmp_b4", {23'd0, bus_a.cmp_clk, bus_a.sar}, {23'd0, 1'b1, 8'h70});
    rst = 1'b1;
    #1;
    check("mid_rst_sar_dout", {16'd0, bus_a.sar, bus_a.dout}, 32'h0);
    check("mid_rst_flags", {28'd0, bus_a.eoc, bus_a.busy, bus_a.s_clk, bus_a.cmp_clk}, 32'h0);
    check("mid_rst_dac", {16'd0, bus_a.dac_top, bus_a.dac_btm}, 32'hFF00);
    @(negedge clk); rst = 1'b0;
    eocs = 0;
    for (int j = 0; j < 30; j++) begin
      @(posedge clk); #1;
      if (bus_a.eoc) eocs++;
    end
    check("mid_rst_no_eoc", 32'(eocs), 32'd0);
    convert(1'b0, 16'h0096);
    check("post_rst_dout", 32'(r_dout), 32'h96);
    check("post_rst_lat",  32'(r_lat), 32'd17);

`ifdef SAR_CTRL_CONT_EN
    code_a = 8'h12;
    sel_b = 1'b0;
    bus_a.cont = 1'b1;
    @(negedge clk); bus_a.cnvst = 1'b1;
    @(posedge clk); #1;
    bus_a.cnvst = 1'b0;
    e1 = -1; e2 = -1; busy_low = 0; d1 = '0; d2 = '0;
    for (int j = 0; j < 60; j++) begin
      if (bus_a.eoc) begin
        if (e1 < 0) begin
          e1 = j; d1 = bus_a.dout;
          if (!bus_a.busy) busy_low++;
          code_a = 8'h34;
          bus_a.cont = 1'b0;
        end else begin
          e2 = j; d2 = bus_a.dout;
          break;
        end
      end else if (!bus_a.busy) busy_low++;
      @(posedge clk); #1;
    end
    check("cont_first_eoc", 32'(e1), 32'd17);
    check("cont_spacing",   32'(e2 - e1), 32'd17);
    check("cont_dout1",     32'(d1), 32'h12);
    check("cont_dout2",     32'(d2), 32'h34);
    check("cont_busy_low",  32'(busy_low), 32'd0);
    repeat (3) @(posedge clk);
`endif

    check("dac_overlap", 32'(overlap), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
